sccb_write_master: RTL and testbench
====================================

SCCB_WRITE_MASTER -- requirements
Module: sccb_write_master

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchroniser depth for scl_ref; values below 2 SHALL be rejected at elaboration.
REQ-002 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 scl_ref  input  1  divided reference clock from the upstream clock divider, at 4x the SCL rate; asynchronous to clk_in.
REQ-005 start  input  1  single-cycle transaction request.
REQ-006 dev_addr  input  8  SCCB write ID; bit 0 SHALL be forced to 0 when transmitted.
REQ-007 reg_addr  input  8  target register address.
REQ-008 wr_data  input  8  register write value.
REQ-009 busy  output  1  high while a transaction is in progress.
REQ-010 done  output  1  one-cycle pulse when a transaction completes.
REQ-011 sioc  output  1  SCCB clock line.
REQ-012 siod_o  output  1  SCCB data value, valid when siod_oe=1.
REQ-013 siod_oe  output  1  data-line drive enable; 0 releases the line to the pull-up.

Function
REQ-014 A tick SHALL be a one-cycle strobe generated on each synchronised rising edge of scl_ref, SYNC_STAGES+1 cycles after the edge.
REQ-015 The FSM SHALL use the states IDLE, START, BIT, STOP and DONE, and SHALL advance only on ticks, except DONE->IDLE, which takes one clk_in cycle.
REQ-016 In IDLE, a start with busy=0 SHALL latch dev_addr, reg_addr and wr_data, and busy SHALL rise on the next cycle.
REQ-017 A start while busy=1 SHALL be ignored, and the latched operands SHALL be unchanged.
REQ-018 START (4 ticks) SHALL drive:
  - q0: sioc=1, siod=1
  - q1: siod=0
  - q2: hold
  - q3: sioc=0
REQ-019 BIT SHALL serialise 3 phases (ID, reg_addr, wr_data) of 9 bits each, MSB first, 4 ticks per bit:
  - q0, q1: sioc=0, data updated at q0
  - q2, q3: sioc=1
REQ-020 The 9th bit of each phase SHALL be don't-care, with siod_oe=0 for that bit.
REQ-021 STOP (4 ticks) SHALL drive:
  - q0: sioc=0, siod=0
  - q1: sioc=1
  - q2: siod released (oe=0)
  - q3: hold
REQ-022 A full transaction SHALL take exactly 116 ticks (4 + 27*4 + 4).
REQ-023 done SHALL pulse in the cycle after the final STOP tick, and busy SHALL fall in that same cycle.
REQ-024 Idle lines SHALL be sioc=1, siod_oe=0.
REQ-025 siod_o SHALL change only while sioc=0; a data transition during sioc=1 is permitted only as the START or STOP condition.
REQ-026 If scl_ref stops, the FSM SHALL hold its state indefinitely, with no timeout.

Reset
REQ-027 While rst_n=0, the outputs SHALL be:
  - sioc=1, siod_o=1, siod_oe=0
  - busy=0, done=0
  - FSM in IDLE, counters and synchroniser cleared
REQ-028 Reset asserted mid-transaction SHALL abort immediately with no STOP generated.
REQ-029 After reset is released, the first tick SHALL NOT be produced by a synchroniser that powers up high; an edge requires an observed 0->1 transition.

Configuration
REQ-030 With SCCB_NACK_CHK_EN defined, the block SHALL add:
  - input siod_i (1 bit), sampled at q2 of every 9th bit
  - output nack (1 bit), which becomes sticky-1 within the transaction if any sample is 1
  - nack cleared on the next accepted start and by reset, and valid while done is high
REQ-031 Without SCCB_NACK_CHK_EN, the ports siod_i and nack SHALL NOT exist, and the 9th bit SHALL be ignored.

Structure
REQ-032 Package sccb_pkg SHALL hold:
  - the state enum
  - NUM_PHASES=3, BITS_PER_PHASE=9, TICKS_PER_BIT=4
  - TXN_TICKS=116
REQ-033 The scl_ref synchroniser and edge detector SHALL be a sub-module, sync_rise_detect, parameterised by SYNC_STAGES.

Verification
REQ-034 Write 0x42/0x12/0x80 with scl_ref divided by 8 from clk_in:
  - decoded bytes on the sioc rising edges SHALL be 0x42, 0x12, 0x80
  - done SHALL arrive after 116 ticks
  - exactly one START and one STOP SHALL occur
REQ-035 dev_addr=0x43 -> transmitted ID SHALL be 0x42.
REQ-036 A start pulsed at tick 50 of an active transaction -> ignored, with operands and timing unchanged.
REQ-037 rst_n low at tick 60 -> sioc=1 and siod_oe=0 within the same cycle; a new transaction after release SHALL complete normally.
REQ-038 With SCCB_NACK_CHK_EN and siod_i=1 during the 2nd phase's 9th bit -> nack=1 at done; the next transaction with siod_i=0 -> nack=0.
REQ-039 scl_ref held low for 1000 cycles mid-BIT -> outputs frozen; resuming scl_ref -> transaction completes correctly.

Source files
------------

// File: rtl/sccb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sccb_pkg: shared state encoding, framing constants and bit selection helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_PHASES     = 3;
  localparam int BITS_PER_PHASE = 9;
  localparam int TICKS_PER_BIT  = 4;
  localparam int TXN_TICKS      = 4 + NUM_PHASES * BITS_PER_PHASE * TICKS_PER_BIT + 4;

  localparam int              Q_W        = $clog2(TICKS_PER_BIT);
  localparam logic [3:0]      LAST_BIT   = 4'(BITS_PER_PHASE - 1);
  localparam logic [1:0]      LAST_PHASE = 2'(NUM_PHASES - 1);

  // MSB-first bit of the byte belonging to the given phase
  function automatic logic phase_bit(input logic [1:0] phase, input logic [3:0] idx,
                                     input logic [7:0] id, input logic [7:0] ra,
                                     input logic [7:0] wd);
    logic [7:0] b;
    logic [2:0] pos;
    case (phase)
      2'd0:    b = id;
      2'd1:    b = ra;
      default: b = wd;
    endcase
    pos = 3'd7 - idx[2:0];
    return b[pos];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_rise_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_rise_detect: multi-stage synchroniser with registered rising-edge strobe.
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_rise_detect: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   w_level;
  logic                   w_valid;

  assign w_level = r_sync[SYNC_STAGES-1];
  assign w_valid = r_fill[SYNC_STAGES-1];

  // r_fill marks when the chain holds real samples; a rise only counts once a
  // genuine low has been seen, so a line that is high at reset release is ignored.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      rise    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= w_level;
      if (w_valid && !w_level) begin
        r_armed <= 1'b1;
      end
      rise <= r_armed && w_level && !r_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sccb_write_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sccb_write_master: 3-phase SCCB register write; SCCB_NACK_CHK_EN adds siod_i/nack.
// Rev 1.0
// ----------------------------------------------------------------------------
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       scl_ref,
  input  logic       start,
  input  logic [7:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe
`ifdef SCCB_NACK_CHK_EN
  ,
  input  logic       siod_i,
  output logic       nack
`endif
);

  state_t           r_state;
  logic [Q_W-1:0]   r_q;
  logic [3:0]       r_bit;
  logic [1:0]       r_phase;
  logic [7:0]       r_id;
  logic [7:0]       r_ra;
  logic [7:0]       r_wd;
  logic             w_tick;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (scl_ref),
    .rise     (w_tick)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_phase <= '0;
      r_id    <= '0;
      r_ra    <= '0;
      r_wd    <= '0;
      sioc    <= 1'b1;
      siod_o  <= 1'b1;
      siod_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SCCB_NACK_CHK_EN
      nack    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_id    <= {dev_addr[7:1], 1'b0};
            r_ra    <= reg_addr;
            r_wd    <= wr_data;
            r_q     <= '0;
            r_bit   <= '0;
            r_phase <= '0;
            busy    <= 1'b1;
            r_state <= START;
`ifdef SCCB_NACK_CHK_EN
            nack    <= 1'b0;
`endif
          end
        end
        START: begin
          if (w_tick) begin
            r_q <= r_q + Q_W'(1);
            case (r_q)
              Q_W'(0): begin
                sioc    <= 1'b1;
                siod_o  <= 1'b1;
                siod_oe <= 1'b1;
              end
              Q_W'(1): siod_o <= 1'b0;
              Q_W'(3): begin
                sioc    <= 1'b0;
                r_state <= BIT;
              end
              default: ;
            endcase
          end
        end
        BIT: begin
          if (w_tick) begin
            r_q <= r_q + Q_W'(1);
            case (r_q)
              Q_W'(0): begin
                sioc <= 1'b0;
                // the 9th bit is released so the slave may drive it
                if (r_bit == LAST_BIT) begin
                  siod_o  <= 1'b1;
                  siod_oe <= 1'b0;
                end else begin
                  siod_o  <= phase_bit(r_phase, r_bit, r_id, r_ra, r_wd);
                  siod_oe <= 1'b1;
                end
              end
              Q_W'(2): begin
                sioc <= 1'b1;
`ifdef SCCB_NACK_CHK_EN
                if (r_bit == LAST_BIT && siod_i) begin
                  nack <= 1'b1;
                end
`endif
              end
              Q_W'(3): begin
                if (r_bit == LAST_BIT) begin
                  r_bit <= '0;
                  if (r_phase == LAST_PHASE) begin
                    r_state <= STOP;
                  end else begin
                    r_phase <= r_phase + 2'd1;
                  end
                end else begin
                  r_bit <= r_bit + 4'd1;
                end
              end
              default: ;
            endcase
          end
        end
        STOP: begin
          if (w_tick) begin
            r_q <= r_q + Q_W'(1);
            case (r_q)
              Q_W'(0): begin
                sioc    <= 1'b0;
                siod_o  <= 1'b0;
                siod_oe <= 1'b1;
              end
              Q_W'(1): sioc <= 1'b1;
              Q_W'(2): begin
                siod_o  <= 1'b1;
                siod_oe <= 1'b0;
              end
              default: begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= DONE;
              end
            endcase
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sccb_write_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sccb_write_master: directed checks of framing, timing, reset and stalls.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sccb_write_master;

  logic       clk_in   = 1'b0;
  logic       rst_n    = 1'b0;
  logic       scl_ref  = 1'b1;
  logic       start    = 1'b0;
  logic [7:0] dev_addr = 8'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data  = 8'h00;
  logic       busy, done, sioc, siod_o, siod_oe;
`ifdef SCCB_NACK_CHK_EN
  logic       siod_i = 1'b0;
  logic       nack;
  logic       obs_nack;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  logic scl_run     = 1'b0;
  int   scl_rises   = 0;

  logic        obs_done, obs_aborted, obs_busy_acc, obs_busy_at_done, obs_done_next, obs_idle_ok;
  logic        obs_rst_sioc, obs_rst_oe, obs_rst_busy, obs_rst_siod;
  int          obs_ticks, obs_nstart, obs_nstop, obs_nrise, obs_ninth_bad, obs_stall_bad;
  logic [23:0] obs_bytes;

  sccb_write_master #(
    .SYNC_STAGES (2)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .scl_ref  (scl_ref),
    .start    (start),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .sioc     (sioc),
    .siod_o   (siod_o),
    .siod_oe  (siod_oe)
`ifdef SCCB_NACK_CHK_EN
    ,
    .siod_i   (siod_i),
    .nack     (nack)
`endif
  );

  always #5 clk_in = ~clk_in;

  // scl_ref = clk_in / 8, toggled on falling clk edges
  initial begin
    forever begin
      repeat (4) @(negedge clk_in);
      if (scl_run) begin
        scl_ref = ~scl_ref;
        if (scl_ref) scl_rises++;
      end
    end
  end

  // mode: 0 plain, 1 start at tick 50, 2 reset at tick 60, 3 stall at tick 40, 4 nack on phase-2 ack
  task automatic run_txn(input logic [7:0] d, input logic [7:0] r, input logic [7:0] w, input int mode);
    int          rise0, tk, guard;
    logic        p_sioc, p_line, line, injected;
    logic [26:0] bits;
    logic [4:0]  snap;
    obs_done = 0; obs_aborted = 0; obs_ticks = -1; obs_nstart = 0; obs_nstop = 0; obs_nrise = 0;
    obs_ninth_bad = 0; obs_stall_bad = 0; obs_busy_at_done = 1'bx; obs_done_next = 1'bx; obs_idle_ok = 0;
    bits = '0; injected = 0;
`ifdef SCCB_NACK_CHK_EN
    obs_nack = 1'bx;
`endif
    @(posedge clk_in); #1;
    guard = 0;
    while (scl_ref !== 1'b1 && guard < 50) begin @(posedge clk_in); #1; guard++; end
    guard = 0;
    while (scl_ref !== 1'b0 && guard < 50) begin @(posedge clk_in); #1; guard++; end
    dev_addr = d; reg_addr = r; wr_data = w; rise0 = scl_rises; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    obs_busy_acc = busy;
    p_sioc = sioc; p_line = siod_oe ? siod_o : 1'b1;
    for (int cyc = 0; cyc < 4000 && !obs_done && !obs_aborted; cyc++) begin
      @(posedge clk_in); #1;
      start = 1'b0;
      tk = scl_rises - rise0;
      line = siod_oe ? siod_o : 1'b1;
      if (p_sioc && sioc && p_line && !line) obs_nstart++;
      if (p_sioc && sioc && !p_line && line) obs_nstop++;
      if (!p_sioc && sioc) begin
        if (obs_nrise < 27) begin
          bits[26-obs_nrise] = line;
          if (obs_nrise % 9 == 8 && siod_oe) obs_ninth_bad++;
        end
        obs_nrise++;
      end
      if (done === 1'b1) begin
        obs_done = 1; obs_ticks = tk; obs_busy_at_done = busy;
`ifdef SCCB_NACK_CHK_EN
        obs_nack = nack;
`endif
      end
      p_sioc = sioc; p_line = line;
      case (mode)
        1: if (tk == 50 && !injected) begin
             injected = 1; start = 1'b1; dev_addr = 8'hFF; reg_addr = 8'hEE; wr_data = 8'hDD;
           end
        2: if (tk == 60) begin
             rst_n = 1'b0; #1;
             obs_rst_sioc = sioc; obs_rst_oe = siod_oe; obs_rst_busy = busy; obs_rst_siod = siod_o;
             obs_aborted = 1;
           end
        3: if (tk == 40 && !injected && scl_ref == 1'b0) begin
             injected = 1; scl_run = 1'b0;
             @(posedge clk_in); #1;
             snap = {sioc, siod_o, siod_oe, busy, done};
             repeat (1000) begin
               @(posedge clk_in); #1;
               if ({sioc, siod_o, siod_oe, busy, done} !== snap) obs_stall_bad++;
             end
             scl_run = 1'b1;
           end
`ifdef SCCB_NACK_CHK_EN
        4: begin
             if (obs_nrise == 17) siod_i = 1'b1;
             if (obs_nrise == 18) siod_i = 1'b0;
           end
`endif
        default: ;
      endcase
    end
    if (obs_done) begin
      @(posedge clk_in); #1;
      obs_done_next = done;
      obs_idle_ok   = (sioc === 1'b1) && (siod_oe === 1'b0);
    end
    obs_bytes = {bits[26:19], bits[17:10], bits[8:1]};
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_in); #1;
    vectors++; if (sioc !== 1'b1) begin miscompares++; $display("FAIL reset_sioc: got %b want 1", sioc); end
    vectors++; if (siod_o !== 1'b1) begin miscompares++; $display("FAIL reset_siod_o: got %b want 1", siod_o); end
    vectors++; if (siod_oe !== 1'b0) begin miscompares++; $display("FAIL reset_siod_oe: got %b want 0", siod_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_powerup_high;
    // scl_ref sits high across release; no tick may advance the accepted START
    dev_addr = 8'h42; reg_addr = 8'h12; wr_data = 8'h80;
    rst_n = 1'b1; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (20) @(posedge clk_in); #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pwrup_busy: got %b want 1", busy); end
    vectors++; if (siod_oe !== 1'b0) begin miscompares++; $display("FAIL pwrup_no_tick_oe: got %b want 0", siod_oe); end
    vectors++; if (sioc !== 1'b1) begin miscompares++; $display("FAIL pwrup_sioc: got %b want 1", sioc); end
    rst_n = 1'b0;
    @(posedge clk_in); #1;
    scl_run = 1'b1;
    repeat (2) @(posedge clk_in); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_in); #1;
  endtask

  task automatic test_write_basic;
    run_txn(8'h42, 8'h12, 8'h80, 0);
    vectors++; if (obs_busy_acc !== 1'b1) begin miscompares++; $display("FAIL basic_busy_rise: got %b want 1", obs_busy_acc); end
    vectors++; if (obs_done !== 1'b1) begin miscompares++; $display("FAIL basic_done_seen: got %b want 1", obs_done); end
    vectors++; if (obs_ticks !== 116) begin miscompares++; $display("FAIL basic_ticks: got %0d want 116", obs_ticks); end
    vectors++; if (obs_bytes !== 24'h421280) begin miscompares++; $display("FAIL basic_bytes: got %h want 421280", obs_bytes); end
    vectors++; if (obs_nstart !== 1) begin miscompares++; $display("FAIL basic_start_cnt: got %0d want 1", obs_nstart); end
    vectors++; if (obs_nstop !== 1) begin miscompares++; $display("FAIL basic_stop_cnt: got %0d want 1", obs_nstop); end
    vectors++; if (obs_nrise !== 28) begin miscompares++; $display("FAIL basic_sioc_rises: got %0d want 28", obs_nrise); end
    vectors++; if (obs_ninth_bad !== 0) begin miscompares++; $display("FAIL basic_ninth_released: got %0d want 0", obs_ninth_bad); end
    vectors++; if (obs_busy_at_done !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done: got %b want 0", obs_busy_at_done); end
    vectors++; if (obs_done_next !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", obs_done_next); end
    vectors++; if (obs_idle_ok !== 1'b1) begin miscompares++; $display("FAIL basic_idle_lines: got %b want 1", obs_idle_ok); end
  endtask

  task automatic test_id_lsb;
    run_txn(8'h43, 8'h00, 8'hFF, 0);
    vectors++; if (obs_bytes !== 24'h4200FF) begin miscompares++; $display("FAIL id_lsb_bytes: got %h want 4200ff", obs_bytes); end
    vectors++; if (obs_ticks !== 116) begin miscompares++; $display("FAIL id_lsb_ticks: got %0d want 116", obs_ticks); end
  endtask

  task automatic test_start_while_busy;
    run_txn(8'h60, 8'h0A, 8'h3C, 1);
    vectors++; if (obs_bytes !== 24'h600A3C) begin miscompares++; $display("FAIL busy_start_bytes: got %h want 600a3c", obs_bytes); end
    vectors++; if (obs_ticks !== 116) begin miscompares++; $display("FAIL busy_start_ticks: got %0d want 116", obs_ticks); end
    vectors++; if (obs_nstart !== 1) begin miscompares++; $display("FAIL busy_start_cnt: got %0d want 1", obs_nstart); end
    vectors++; if (obs_nstop !== 1) begin miscompares++; $display("FAIL busy_stop_cnt: got %0d want 1", obs_nstop); end
  endtask

  task automatic test_reset_mid;
    run_txn(8'hA5, 8'h3C, 8'h5A, 2);
    vectors++; if (obs_aborted !== 1'b1) begin miscompares++; $display("FAIL rstmid_reached: got %b want 1", obs_aborted); end
    vectors++; if (obs_rst_sioc !== 1'b1) begin miscompares++; $display("FAIL rstmid_sioc: got %b want 1", obs_rst_sioc); end
    vectors++; if (obs_rst_oe !== 1'b0) begin miscompares++; $display("FAIL rstmid_oe: got %b want 0", obs_rst_oe); end
    vectors++; if (obs_rst_siod !== 1'b1) begin miscompares++; $display("FAIL rstmid_siod: got %b want 1", obs_rst_siod); end
    vectors++; if (obs_rst_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", obs_rst_busy); end
    vectors++; if (obs_nstop !== 0) begin miscompares++; $display("FAIL rstmid_no_stop: got %0d want 0", obs_nstop); end
    repeat (3) @(posedge clk_in); #1;
    rst_n = 1'b1;
    run_txn(8'h42, 8'h12, 8'h80, 0);
    vectors++; if (obs_done !== 1'b1) begin miscompares++; $display("FAIL rstmid_after_done: got %b want 1", obs_done); end
    vectors++; if (obs_ticks !== 116) begin miscompares++; $display("FAIL rstmid_after_ticks: got %0d want 116", obs_ticks); end
    vectors++; if (obs_bytes !== 24'h421280) begin miscompares++; $display("FAIL rstmid_after_bytes: got %h want 421280", obs_bytes); end
  endtask

  task automatic test_stall;
    run_txn(8'h21, 8'h34, 8'hC7, 3);
    vectors++; if (obs_stall_bad !== 0) begin miscompares++; $display("FAIL stall_frozen: got %0d changes want 0", obs_stall_bad); end
    vectors++; if (obs_done !== 1'b1) begin miscompares++; $display("FAIL stall_done: got %b want 1", obs_done); end
    vectors++; if (obs_ticks !== 116) begin miscompares++; $display("FAIL stall_ticks: got %0d want 116", obs_ticks); end
    vectors++; if (obs_bytes !== 24'h2034C7) begin miscompares++; $display("FAIL stall_bytes: got %h want 2034c7", obs_bytes); end
  endtask

`ifdef SCCB_NACK_CHK_EN
  task automatic test_nack;
    run_txn(8'h42, 8'h12, 8'h80, 4);
    vectors++; if (obs_nack !== 1'b1) begin miscompares++; $display("FAIL nack_set: got %b want 1", obs_nack); end
    run_txn(8'h42, 8'h12, 8'h80, 0);
    vectors++; if (obs_nack !== 1'b0) begin miscompares++; $display("FAIL nack_clear: got %b want 0", obs_nack); end
  endtask
`endif

  initial begin
    test_reset;
    test_powerup_high;
    test_write_basic;
    test_id_lsb;
    test_start_while_busy;
    test_reset_mid;
    test_stall;
`ifdef SCCB_NACK_CHK_EN
    test_nack;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
